dmem_ws: RTL and testbench
==========================

// Module: dmem_ws
// PURPOSE
//  Parametrised data-memory subsystem for the pipelined RISC-V core's memory (M) stage.
//  Generalises the flat word-only dmem with several additions:
//   - byte/half/word loads and stores, with sign or zero extension on loads
//   - configurable wait states, signalled to the pipeline through a stall handshake
//   - misalignment detection
//   - two memory-mapped registers: a GPIO output register and a free-running cycle counter
//  Sits between the core's M-stage outputs and the writeback path.
// PARAMETERS
//  DEPTH_WORDS  64            RAM depth in 32-bit words; power of 2, >= 4
//  WAIT_STATES  2             stall cycles per aligned access; legal range 0..15
//  GPIO_ADDR    32'h0000_1000 byte address of the GPIO register (R/W)
//  CYCLE_ADDR   32'h0000_1004 byte address of the cycle counter (read-only)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  MemReadM    in   1   load request
//  MemWriteM   in   1   store request
//  ALUResultM  in   32  byte address
//  WriteDataM  in   32  store data, right-aligned
//  Funct3M     in   3   size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  ReadDataM   out  32  load result; valid only in the completion cycle, else 0
//  StallM      out  1   1 = hold the M stage and everything upstream
//  MisalignM   out  1   combinational: current request is misaligned
//  ErrFlag     out  1   sticky misalignment flag
//  GpioOut     out  32  GPIO register contents
// BEHAVIOUR
//  Reset values:
//   - state IDLE, wait counter cnt 0, cycle counter 0
//   - GpioOut 0, ErrFlag 0
//   - outputs StallM 0, ReadDataM 0, MisalignM 0
//   - RAM contents are not reset
//  Request definitions:
//   - req = MemReadM | MemWriteM
//   - If MemReadM and MemWriteM are both high, the request is a write; ReadDataM = 0.
//  Alignment:
//   - h/hu misaligned if addr[0] = 1
//   - w misaligned if addr[1:0] != 0
//   - b/bu are never misaligned
//  Misaligned request:
//   - MisalignM = 1 in the same cycle; StallM = 0; no write; ReadDataM = 0
//   - ErrFlag set at the next edge; cleared only by reset
//  FSM states IDLE and BUSY:
//   - IDLE, aligned req, WAIT_STATES = 0: completion cycle, StallM = 0
//   - IDLE, aligned req, WAIT_STATES > 0: StallM = 1, cnt <= WAIT_STATES-1, next state BUSY
//   - BUSY, cnt != 0: StallM = 1, cnt <= cnt-1
//   - BUSY, cnt = 0: completion cycle, StallM = 0, next state IDLE
//  Handshake and latency:
//   - The pipeline holds its request inputs stable while StallM = 1.
//   - Each access occupies WAIT_STATES+1 cycles; back-to-back requests each pay the full cost.
//  Completion cycle:
//   - Loads: ReadDataM is driven combinationally.
//   - Stores: data commits at the closing clock edge.
//  Store lanes:
//   - sb writes lane addr[1:0] with WriteDataM[7:0]
//   - sh writes half addr[1] with WriteDataM[15:0]
//   - sw writes the whole word
//  Load extraction:
//   - Take the same lane as the store rules.
//   - b/h sign-extend; bu/hu zero-extend.
//  Address decode, in priority order:
//   1. word address == GPIO_ADDR[31:2]: R/W GPIO register; stores apply the byte lanes above
//   2. word address == CYCLE_ADDR[31:2]: reads return the counter value in the completion cycle; writes ignored
//   3. otherwise: RAM index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliasing/wrap)
//  Cycle counter:
//   - increments every clock
//   - wraps 0xFFFFFFFF -> 0
//  Reset mid-access (asserted in BUSY):
//   - state goes to IDLE and StallM drops immediately
//   - the pending store is abandoned; the target is unchanged
// TESTING
//  1. WAIT_STATES=2, sw 0xDEADBEEF @0x8 -> StallM=1 for 2 cycles, 0 on the 3rd; then lw @0x8 -> ReadDataM=0xDEADBEEF in its 3rd cycle.
//  2. After test 1: sb 0x80 @0x9 -> lb @0x9=0xFFFFFF80, lbu @0x9=0x00000080, lw @0x8=0xDEAD80EF; sh 0x1234 @0xA -> lw @0x8=0x123480EF.
//  3. lw @0x6 -> MisalignM=1 same cycle, StallM=0, ReadDataM=0, ErrFlag=1 next cycle; lw @0x4 shows the word unchanged.
//  4. sw 0x000000A5 @0x1000 -> GpioOut=0xA5 after the completion edge; two lw @0x1004 issued back-to-back differ by WAIT_STATES+1.
//  5. Assert reset during BUSY of sw 0x5A5A5A5A @0x10 -> StallM=0 immediately, @0x10 keeps its old value, GpioOut=0, ErrFlag=0.
//  6. WAIT_STATES=0, DEPTH_WORDS=64: sw 0x11 @0x0 then lw @0x100 (aliases word 0) -> 0x00000011 with StallM never asserted.

Source files
------------

// File: rtl/dmem_ws.sv
// dmem_ws: data memory for the M stage of the pipelined RISC-V core.
// Handles byte/half/word loads and stores with sign/zero extension,
// configurable wait states through a stall handshake, and misalignment
// detection. Two memory-mapped registers sit beside the RAM: a GPIO
// output register and a free-running cycle counter.
module dmem_ws #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] GPIO_ADDR   = 32'h0000_1000,
  parameter logic [31:0] CYCLE_ADDR  = 32'h0000_1004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        ErrFlag,
  output logic [31:0] GpioOut
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter load value on entering BUSY; unused when there are no wait states.
  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Byte and unsigned-byte accesses can never be misaligned. Halves need
  // addr[0] = 0. Words, and any unassigned size code, need addr[1:0] = 0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = off[0];
      default:        m = (off != 2'b00);
    endcase
    return m;
  endfunction

  // Merge right-aligned store data into the old word on the addressed lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = old_w;
    case (f3[1:0])
      2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (off[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] gpio_q, gpio_d;
  logic        err_q, err_d;

  logic          req;
  logic          misalign;
  logic          stall;
  logic          done;
  logic          sel_gpio;
  logic          sel_cyc;
  logic [AW-1:0] ram_idx;
  logic [31:0]   cur_word;
  logic [31:0]   store_word;
  logic          do_store;
  logic          ram_we;

  // Request qualification and address decode (GPIO beats counter beats RAM).
  always_comb begin
    req      = MemReadM | MemWriteM;
    misalign = req & is_misaligned(Funct3M, ALUResultM[1:0]);
    sel_gpio = (ALUResultM[31:2] == GPIO_ADDR[31:2]);
    sel_cyc  = ~sel_gpio & (ALUResultM[31:2] == CYCLE_ADDR[31:2]);
    ram_idx  = ALUResultM[AW+1:2];
    if (sel_gpio) begin
      cur_word = gpio_q;
    end else if (sel_cyc) begin
      cur_word = cycle_q;
    end else begin
      cur_word = mem[ram_idx];
    end
  end

  // Wait-state FSM: decides stall versus completion for the current request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !misalign) begin
          if (WAIT_STATES == 0) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = WS_INIT;
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Datapath: store merge, register updates and the gated combinational outputs.
  always_comb begin
    store_word = store_merge(cur_word, WriteDataM, Funct3M, ALUResultM[1:0]);
    // A store held across a reset edge must never land.
    do_store   = done & MemWriteM & ~reset;
    ram_we     = do_store & ~sel_gpio & ~sel_cyc;
    if (do_store && sel_gpio) begin
      gpio_d = store_word;
    end else begin
      gpio_d = gpio_q;
    end
    err_d   = err_q | misalign;
    cycle_d = cycle_q + 32'd1;
    if (done && MemReadM && !MemWriteM && !reset) begin
      ReadDataM = load_extract(cur_word, Funct3M, ALUResultM[1:0]);
    end else begin
      ReadDataM = 32'd0;
    end
    StallM    = stall & ~reset;
    MisalignM = misalign & ~reset;
  end

  // Control and memory-mapped register state, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cycle_q <= 32'd0;
      gpio_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cycle_q <= cycle_d;
      gpio_q  <= gpio_d;
      err_q   <= err_d;
    end
  end

  // RAM array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= store_word;
    end
  end

  assign GpioOut = gpio_q;
  assign ErrFlag = err_q;

endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: directed-vector bench for dmem_ws. One instance with two
// wait states covers the main scenarios; a zero-wait-state instance
// covers the no-stall path and address aliasing.
module tb_dmem_ws;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  Funct3M;

  logic [31:0] rd2, gpio2, rd0, gpio0;
  logic        stall2, mis2, err2, stall0, mis0, err0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r, s, c1, c2;
  logic        m;

  dmem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Funct3M(Funct3M),
    .ReadDataM(rd2), .StallM(stall2), .MisalignM(mis2), .ErrFlag(err2), .GpioOut(gpio2)
  );

  dmem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Funct3M(Funct3M),
    .ReadDataM(rd0), .StallM(stall0), .MisalignM(mis0), .ErrFlag(err0), .GpioOut(gpio0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the two-wait-state instance: present the request, count
  // stall cycles, capture the completion-cycle data, release after the edge.
  task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic [31:0] stalls,
                     output logic mis);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    #1;
    stalls = 32'd0;
    mis    = mis2;
    while (stall2 === 1'b1 && stalls < 32'd40) begin
      stalls = stalls + 32'd1;
      @(negedge clk);
      #1;
    end
    if (stall2 !== 1'b0) chk("stall_timeout", {31'd0, stall2}, 32'd0);
    rdata = rd2;
    @(posedge clk);
    #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // One single-cycle access on the zero-wait-state instance.
  task automatic acc0(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic stl);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    #1;
    stl   = stall0;
    rdata = rd0;
    @(posedge clk);
    #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; Funct3M = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall2}, 32'd0);
    chk("rst_rdata", rd2, 32'd0);
    chk("rst_mis", {31'd0, mis2}, 32'd0);
    chk("rst_err", {31'd0, err2}, 32'd0);
    chk("rst_gpio", gpio2, 32'd0);
    chk("rst_gpio0", gpio0, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: word store and load with two wait states
    acc(1'b0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, r, s, m);
    chk("t1_sw_stalls", s, 32'd2);
    chk("t1_sw_rdata", r, 32'd0);
    acc(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, r, s, m);
    chk("t1_lw_stalls", s, 32'd2);
    chk("t1_lw", r, 32'hDEADBEEF);

    // 2: sub-word stores and sign/zero-extended loads
    acc(1'b0, 1'b1, 3'b000, 32'h9, 32'h80, r, s, m);
    acc(1'b1, 1'b0, 3'b000, 32'h9, 32'd0, r, s, m);
    chk("t2_lb", r, 32'hFFFFFF80);
    acc(1'b1, 1'b0, 3'b100, 32'h9, 32'd0, r, s, m);
    chk("t2_lbu", r, 32'h00000080);
    acc(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, r, s, m);
    chk("t2_lw_after_sb", r, 32'hDEAD80EF);
    acc(1'b0, 1'b1, 3'b001, 32'hA, 32'h1234, r, s, m);
    acc(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, r, s, m);
    chk("t2_lw_after_sh", r, 32'h123480EF);
    acc(1'b1, 1'b0, 3'b101, 32'hA, 32'd0, r, s, m);
    chk("t2_lhu", r, 32'h00001234);
    acc(1'b1, 1'b0, 3'b000, 32'h8, 32'd0, r, s, m);
    chk("t2_lb_lane0", r, 32'hFFFFFFEF);

    // 3: misalignment
    acc(1'b0, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, r, s, m);
    chk("t3_err_before", {31'd0, err2}, 32'd0);
    acc(1'b1, 1'b0, 3'b010, 32'h6, 32'd0, r, s, m);
    chk("t3_lw_mis", {31'd0, m}, 32'd1);
    chk("t3_lw_mis_stall", s, 32'd0);
    chk("t3_lw_mis_rdata", r, 32'd0);
    chk("t3_err_set", {31'd0, err2}, 32'd1);
    acc(1'b0, 1'b1, 3'b010, 32'h6, 32'h11111111, r, s, m);
    chk("t3_sw_mis", {31'd0, m}, 32'd1);
    acc(1'b0, 1'b1, 3'b001, 32'h5, 32'h2222, r, s, m);
    chk("t3_sh_mis", {31'd0, m}, 32'd1);
    acc(1'b1, 1'b0, 3'b010, 32'h4, 32'd0, r, s, m);
    chk("t3_word_unchanged", r, 32'hCAFEF00D);
    chk("t3_aligned_no_mis", {31'd0, m}, 32'd0);

    // 4: GPIO register and cycle counter
    acc(1'b0, 1'b1, 3'b010, 32'h1000, 32'h000000A5, r, s, m);
    chk("t4_gpio", gpio2, 32'h000000A5);
    acc(1'b0, 1'b1, 3'b000, 32'h1001, 32'h7F, r, s, m);
    chk("t4_gpio_sb", gpio2, 32'h00007FA5);
    acc(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, r, s, m);
    chk("t4_gpio_read", r, 32'h00007FA5);
    acc(1'b1, 1'b0, 3'b010, 32'h1004, 32'd0, c1, s, m);
    acc(1'b1, 1'b0, 3'b010, 32'h1004, 32'd0, c2, s, m);
    chk("t4_cycle_delta", c2 - c1, 32'd3);

    // 5: reset asserted while BUSY on a store
    acc(1'b0, 1'b1, 3'b010, 32'h10, 32'h0BADCAFE, r, s, m);
    @(negedge clk);
    MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h10; WriteDataM = 32'h5A5A5A5A;
    #1;
    chk("t5_stall_idle", {31'd0, stall2}, 32'd1);
    @(posedge clk);
    #1;
    chk("t5_stall_busy", {31'd0, stall2}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_stall_drop", {31'd0, stall2}, 32'd0);
    chk("t5_gpio_rst", gpio2, 32'd0);
    chk("t5_err_rst", {31'd0, err2}, 32'd0);
    @(negedge clk);
    MemWriteM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, r, s, m);
    chk("t5_store_abandoned", r, 32'h0BADCAFE);

    // 6: zero wait states and RAM aliasing
    acc0(1'b0, 1'b1, 3'b010, 32'h0, 32'h11, r, m);
    chk("t6_sw_nostall", {31'd0, m}, 32'd0);
    acc0(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, r, m);
    chk("t6_lw_nostall", {31'd0, m}, 32'd0);
    chk("t6_alias", r, 32'h00000011);
    chk("t6_no_mis", {31'd0, mis0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
